// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 2-flop sync, mid-bit sampling, 8N1 frames.
// Define UART_RX_PARITY_EN to add an even-parity bit and o_parity_err.
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_dout,
  output logic       o_rx_done,
  output logic       o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       o_parity_err,
`endif
  output logic       o_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] TICK_V = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_V = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          sync1;
  logic          rx_s;
  logic          rx_prev;
  logic          tick;
  logic          good_par;

  assign tick   = (cnt == TICK_V);
  assign o_busy = (state != S_IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign good_par = ~^{shreg, par_bit};
`else
  assign good_par = 1'b1;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      sync1       <= 1'b1;
      rx_s        <= 1'b1;
      rx_prev     <= 1'b1;
      o_dout      <= 8'h00;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      sync1       <= i_rx;
      rx_s        <= sync1;
      rx_prev     <= rx_s;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (rx_prev && !rx_s) state <= S_START;
        end
        S_START: begin
          if (cnt == HALF_V) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DATA: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_idx == 3'd7) state <= S_PARITY;
`else
            if (bit_idx == 3'd7) state <= S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          if (tick) begin
            par_bit <= rx_s;
            state   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          cnt <= tick ? '0 : cnt + 1'b1;
          // leave mid stop bit so a following start edge is not missed
          if (tick) begin
            state <= S_IDLE;
            if (!rx_s) begin
              o_frame_err <= 1'b1;
            end else if (good_par) begin
              o_dout    <= shreg;
              o_rx_done <= 1'b1;
            end else begin
`ifdef UART_RX_PARITY_EN
              o_parity_err <= 1'b1;
`endif
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer at CLKS_PER_BIT=16.
// Honours UART_RX_PARITY_EN for frame shape and the parity test.
module tb_uart_rx_deframer;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 155 + CPB;
`else
  localparam int LAT = 155;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] dout;
  logic       done;
  logic       ferr;
  logic       busy;
  logic       perr;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_n   = 0;
  int ferr_n   = 0;
  int perr_n   = 0;
  int both_n   = 0;
  int last_done_cyc = 0;
  int t0;

  uart_rx_deframer #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_rx        (rx),
    .o_dout      (dout),
    .o_rx_done   (done),
    .o_frame_err (ferr),
`ifdef UART_RX_PARITY_EN
    .o_parity_err(perr),
`endif
    .o_busy      (busy)
  );

`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      done_n <= done_n + 1;
      last_done_cyc <= cyc;
    end
    if (ferr) ferr_n <= ferr_n + 1;
    if (perr) perr_n <= perr_n + 1;
    if (done && ferr) both_n <= both_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bit_out(input logic b, input int n);
    rx = b;
    wait_cyc(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input logic bad_par);
    t0 = cyc;
    bit_out(1'b0, CPB);
    for (int i = 0; i < 8; i++) bit_out(d[i], CPB);
`ifdef UART_RX_PARITY_EN
    bit_out((^d) ^ bad_par, CPB);
`else
    if (bad_par) $display("note: parity not compiled in");
`endif
    bit_out(stop, CPB);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(40);
    chk("reset_dout", 32'(dout), 32'h00);
    chk("reset_done_n", 32'(done_n), 0);
    chk("reset_ferr_n", 32'(ferr_n), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_perr", 32'(perr), 0);

    send_frame(8'hA5, 1'b1, 1'b0);
    chk("a5_dout", 32'(dout), 32'hA5);
    chk("a5_done_n", 32'(done_n), 1);
    chk("a5_latency", 32'(last_done_cyc - t0), 32'(LAT));
    chk("a5_busy_after", 32'(busy), 0);
    chk("a5_ferr_n", 32'(ferr_n), 0);

    send_frame(8'h3C, 1'b1, 1'b0);
    chk("b2b_3c", 32'(dout), 32'h3C);
    send_frame(8'hFF, 1'b1, 1'b0);
    chk("b2b_ff", 32'(dout), 32'hFF);
    chk("b2b_done_n", 32'(done_n), 3);

    send_frame(8'h55, 1'b0, 1'b0);
    bit_out(1'b0, 40);
    bit_out(1'b1, 20);
    chk("ferr_n", 32'(ferr_n), 1);
    chk("ferr_dout_kept", 32'(dout), 32'hFF);
    chk("ferr_no_done", 32'(done_n), 3);
    send_frame(8'h12, 1'b1, 1'b0);
    chk("after_ferr_dout", 32'(dout), 32'h12);
    chk("after_ferr_done_n", 32'(done_n), 4);

    bit_out(1'b0, 4);
    bit_out(1'b1, 2);
    chk("glitch_busy", 32'(busy), 1);
    wait_cyc(30);
    chk("glitch_idle", 32'(busy), 0);
    chk("glitch_done_n", 32'(done_n), 4);
    chk("glitch_ferr_n", 32'(ferr_n), 1);
    chk("glitch_dout", 32'(dout), 32'h12);

    bit_out(1'b0, CPB);
    bit_out(1'b1, CPB);
    for (int i = 1; i < 4; i++) bit_out(1'b0, CPB);
    bit_out(1'b0, 8);
    rst = 1'b1;
    rx  = 1'b1;
    wait_cyc(2);
    rst = 1'b0;
    chk("midrst_dout", 32'(dout), 32'h00);
    chk("midrst_busy", 32'(busy), 0);
    wait_cyc(20);
    chk("midrst_no_done", 32'(done_n), 4);
    send_frame(8'h81, 1'b1, 1'b0);
    chk("rst_then_81", 32'(dout), 32'h81);
    chk("rst_then_done_n", 32'(done_n), 5);

`ifdef UART_RX_PARITY_EN
    bit_out(1'b1, 10);
    send_frame(8'h07, 1'b1, 1'b1);
    chk("par_err_n", 32'(perr_n), 1);
    chk("par_no_done", 32'(done_n), 5);
    chk("par_dout_kept", 32'(dout), 32'h81);
`endif

    chk("no_overlap", 32'(both_n), 0);
    chk("no_perr_total", 32'(perr_n),
`ifdef UART_RX_PARITY_EN
        1
`else
        0
`endif
    );

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
